// File: rtl/packet_serializer_pkg.sv
// rtl/packet_serializer_pkg.sv - shared states, section sizes and sync words for the packet serializer
package packet_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        FOOTER
    } state_t;

    localparam int          HEADER_BYTES        = 8;
    localparam int          FOOTER_BYTES        = 8;
    localparam logic [31:0] DEFAULT_HEADER_SYNC = 32'h41485021;
    localparam logic [31:0] DEFAULT_FOOTER_SYNC = 32'h21504841;

    // Byte idx of a 64-bit word, counted from the most significant byte.
    function automatic logic [7:0] byte_of64(input logic [63:0] word, input logic [2:0] idx);
        logic [63:0] shifted;
        shifted = word << {idx, 3'b000};
        return shifted[63:56];
    endfunction

endpackage

// File: rtl/packet_serializer_if.sv
// rtl/packet_serializer_if.sv - byte stream towards the UART transmitter
interface packet_serializer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/packet_serializer_byte_mux.sv
// rtl/packet_serializer_byte_mux.sv - picks one byte of the snapshot, index 0 is the most significant byte
module byte_mux #(
    parameter int WIDTH = 3456,
    parameter int IDX_W = 9
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       data
);

    localparam int NBYTES = WIDTH / 8;

    always_comb begin
        data = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IDX_W'(i)) begin
                data = vec[WIDTH-1-8*i -: 8];
            end
        end
    end

endmodule

// File: rtl/packet_serializer.sv
// rtl/packet_serializer.sv - snapshots the correlator vector and streams it as header/payload/footer bytes
module packet_serializer
    import packet_serializer_pkg::*;
#(
    parameter int          PAYLOAD_SIZE = 3456,
    parameter logic [31:0] HEADER_SYNC  = DEFAULT_HEADER_SYNC,
    parameter logic [31:0] FOOTER_SYNC  = DEFAULT_FOOTER_SYNC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_SIZE-1:0] pulses,
    input  logic                    start,
    packet_serializer_if.master     tx,
    output logic                    clear_accum,
    output logic                    busy,
    output logic                    done
);

    localparam int               NBYTES   = PAYLOAD_SIZE / 8;
    localparam int               IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] PAY_LAST = IDX_W'(NBYTES - 1);
    localparam logic [2:0]       HDR_LAST = 3'(HEADER_BYTES - 1);
    localparam logic [2:0]       FTR_LAST = 3'(FOOTER_BYTES - 1);

    state_t                  state, state_next;
    logic [2:0]              hdr_idx, hdr_idx_next;
    logic [IDX_W-1:0]        pay_idx, pay_idx_next;
    logic [2:0]              ftr_idx, ftr_idx_next;
    logic [PAYLOAD_SIZE-1:0] shadow;
    logic [31:0]             seq;
    logic [15:0]             csum;
    logic [7:0]              pay_byte;
    logic                    fire;
    logic                    load;
    logic                    pkt_end;

    byte_mux #(.WIDTH(PAYLOAD_SIZE), .IDX_W(IDX_W)) u_byte_mux (
        .vec  (shadow),
        .idx  (pay_idx),
        .data (pay_byte)
    );

    assign tx.tx_valid = (state != IDLE);
    assign busy        = (state != IDLE);
    assign fire        = tx.tx_valid & tx.tx_ready;

    always_comb begin
        tx.tx_data = 8'h00;
        case (state)
            HEADER:  tx.tx_data = byte_of64({HEADER_SYNC, seq}, hdr_idx);
            PAYLOAD: tx.tx_data = pay_byte;
            FOOTER:  tx.tx_data = byte_of64({csum, 16'h0000, FOOTER_SYNC}, ftr_idx);
            default: tx.tx_data = 8'h00;
        endcase
    end

    // done is high in the first idle cycle, so gating on it keeps that cycle deaf to start.
    always_comb begin
        state_next   = state;
        hdr_idx_next = hdr_idx;
        pay_idx_next = pay_idx;
        ftr_idx_next = ftr_idx;
        load         = 1'b0;
        pkt_end      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done) begin
                    load       = 1'b1;
                    state_next = HEADER;
                end
            end
            HEADER: begin
                if (fire) begin
                    if (hdr_idx == HDR_LAST) begin
                        state_next   = PAYLOAD;
                        hdr_idx_next = '0;
                    end else begin
                        hdr_idx_next = hdr_idx + 3'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (fire) begin
                    if (pay_idx == PAY_LAST) begin
                        state_next   = FOOTER;
                        pay_idx_next = '0;
                    end else begin
                        pay_idx_next = pay_idx + IDX_W'(1);
                    end
                end
            end
            FOOTER: begin
                if (fire) begin
                    if (ftr_idx == FTR_LAST) begin
                        state_next   = IDLE;
                        ftr_idx_next = '0;
                        pkt_end      = 1'b1;
                    end else begin
                        ftr_idx_next = ftr_idx + 3'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hdr_idx     <= '0;
            pay_idx     <= '0;
            ftr_idx     <= '0;
            clear_accum <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            hdr_idx     <= hdr_idx_next;
            pay_idx     <= pay_idx_next;
            ftr_idx     <= ftr_idx_next;
            clear_accum <= load;
            done        <= pkt_end;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
            seq    <= '0;
            csum   <= '0;
        end else begin
            if (load) begin
                shadow <= pulses;
                csum   <= '0;
            end else if (state == PAYLOAD && fire) begin
                csum <= csum + {8'h00, pay_byte};
            end
            if (pkt_end) begin
                seq <= seq + 32'd1;
            end
        end
    end

endmodule
